// File: rtl/clk_div_monitor.sv
// clk_div_monitor: frequency/lock checker for the divide-by-4.5 clock.
// The divided clock is treated as data in the clk domain: it is synchronized,
// its rising edges are counted over a fixed window, and the count is compared
// against the expected value to build a lock indication and a sticky error.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | measurement off; window, accumulator and good count held at 0
// ST_ACQUIRE | measuring; counting consecutive good windows toward lock
// ST_LOCKED  | LOCK_CNT good windows seen; a bad window drops lock, sets err
module clk_div_monitor #(
  parameter int WINDOW    = 36,
  parameter int EXP_EDGES = 8,
  parameter int TOL       = 1,
  parameter int LOCK_CNT  = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_clk_in,
  input  logic             clear_err,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             locked,
  output logic             err
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int GC_W  = $clog2(LOCK_CNT + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [GC_W-1:0]  LOCK_V   = GC_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] EXP_V    = CNT_W'(EXP_EDGES);
  localparam logic [CNT_W-1:0] TOL_V    = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [GC_W-1:0]  gcnt_q, gcnt_d;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic             count_valid_q, count_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic             rise;
  logic [CNT_W-1:0] acc_inc;
  logic [CNT_W-1:0] diff;
  logic             good;
  logic             win_end;
  logic [GC_W-1:0]  gcnt_inc;

  // Edge detect and window bookkeeping shared by every state.
  always_comb begin
    s1_d     = div_clk_in;
    s2_d     = s1_q;
    s3_d     = s2_q;
    rise     = s2_q & ~s3_q;
    acc_inc  = (acc_q == CNT_MAX) ? acc_q : acc_q + CNT_W'(rise);
    // Absolute distance from the expected count without going negative.
    diff     = (acc_inc >= EXP_V) ? (acc_inc - EXP_V) : (EXP_V - acc_inc);
    good     = (diff <= TOL_V);
    win_end  = (win_q == WIN_LAST);
    gcnt_inc = gcnt_q + GC_W'(1);
  end

  // Next-state logic for the FSM, window counter, accumulator and outputs.
  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    acc_d         = acc_q;
    gcnt_d        = gcnt_q;
    edge_count_d  = edge_count_q;
    count_valid_d = 1'b0;
    locked_d      = locked_q;
    err_d         = err_q;

    // Clear first so a loss-of-lock set below on the same cycle wins.
    if (clear_err) err_d = 1'b0;

    case (state_q)
      ST_ACQUIRE, ST_LOCKED: begin
        if (!enable) begin
          // Abandon the partial window; edge_count and err are kept.
          state_d  = ST_IDLE;
          win_d    = '0;
          acc_d    = '0;
          gcnt_d   = '0;
          locked_d = 1'b0;
        end else if (win_end) begin
          win_d         = '0;
          acc_d         = '0;
          edge_count_d  = acc_inc;
          count_valid_d = 1'b1;
          if (state_q == ST_ACQUIRE) begin
            if (good) begin
              gcnt_d = gcnt_inc;
              if (gcnt_inc == LOCK_V) begin
                state_d  = ST_LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              gcnt_d = '0;
            end
          end else if (!good) begin
            state_d  = ST_ACQUIRE;
            gcnt_d   = '0;
            locked_d = 1'b0;
            err_d    = 1'b1;
          end
        end else begin
          win_d = win_q + WIN_W'(1);
          acc_d = acc_inc;
        end
      end
      default: begin
        win_d    = '0;
        acc_d    = '0;
        gcnt_d   = '0;
        locked_d = 1'b0;
        state_d  = enable ? ST_ACQUIRE : ST_IDLE;
      end
    endcase
  end

  // All state registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      win_q         <= '0;
      acc_q         <= '0;
      gcnt_q        <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      win_q         <= win_d;
      acc_q         <= acc_d;
      gcnt_q        <= gcnt_d;
      edge_count_q  <= edge_count_d;
      count_valid_q <= count_valid_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign edge_count  = edge_count_q;
  assign count_valid = count_valid_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: drives synthetic divided clocks (4.5, 4, 3, stuck
// low) on clk half-period slots and checks window counts, lock and error.
module tb_clk_div_monitor;

  localparam int WINDOW   = 36;
  localparam int LOCK_CNT = 4;
  localparam int CNT_W    = 8;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             div_clk_in;
  logic             clear_err;
  logic [CNT_W-1:0] edge_count;
  logic             count_valid;
  logic             locked;
  logic             err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mode   = 0;  // 0: div 4.5, 1: div 4, 2: div 3, 3: stuck low
  int cv_cyc = 0;
  int sb_q[$];

  typedef struct {
    int mode;
    int nwin;
    int exp_cnt;
    bit exp_lock;
    bit exp_err;
  } vec_t;

  vec_t vecs[4];

  clk_div_monitor #(
    .WINDOW(WINDOW), .EXP_EDGES(8), .TOL(1), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .div_clk_in(div_clk_in),
    .clear_err(clear_err), .edge_count(edge_count), .count_valid(count_valid),
    .locked(locked), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Divided-clock source: one value per clk half period, offset from the edges.
  initial begin
    int slot;
    slot = 0;
    div_clk_in = 1'b0;
    #2;
    forever begin
      case (mode)
        0: div_clk_in = ((slot % 9) < 5);
        1: div_clk_in = ((slot % 8) < 4);
        2: div_clk_in = ((slot % 6) < 3);
        default: div_clk_in = 1'b0;
      endcase
      #5;
      slot++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  // Wait for the next count_valid pulse; a missing pulse is a failed check.
  task automatic wait_cv(output bit ok);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!count_valid && n < 100);
    ok = count_valid;
    cv_cyc = cyc;
    if (!ok) chk("cv_timeout", 0, 1);
  endtask

  // Expected count queued with the stimulus, popped when the window reports.
  task automatic sb_window(input string name, input int exp_cnt);
    bit ok;
    int e;
    sb_q.push_back(exp_cnt);
    wait_cv(ok);
    e = sb_q.pop_front();
    if (ok) chk(name, int'(edge_count), e);
  endtask

  task automatic wait_locked();
    int n;
    n = 0;
    while (!locked && n < 600) begin
      tick();
      n++;
    end
    if (!locked) chk("lock_timeout", 0, 1);
  endtask

  task automatic restart(input int m);
    enable = 1'b0;
    repeat (3) tick();
    mode = m;
    repeat (6) tick();
    enable = 1'b1;
  endtask

  initial begin
    int n;
    int w0;
    bit ok;

    vecs[0] = '{mode: 0, nwin: 5, exp_cnt: 8,  exp_lock: 1'b1, exp_err: 1'b0};
    vecs[1] = '{mode: 1, nwin: 5, exp_cnt: 9,  exp_lock: 1'b1, exp_err: 1'b0};
    vecs[2] = '{mode: 2, nwin: 5, exp_cnt: 12, exp_lock: 1'b0, exp_err: 1'b0};
    vecs[3] = '{mode: 3, nwin: 2, exp_cnt: 0,  exp_lock: 1'b0, exp_err: 1'b0};

    reset = 1'b0;
    enable = 1'b0;
    clear_err = 1'b0;
    repeat (3) tick();
    chk("rst_edge_count", int'(edge_count), 0);
    chk("rst_count_valid", int'(count_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b1;

    // Steady-state windows for each stimulus pattern.
    for (int i = 0; i < 4; i++) begin
      restart(vecs[i].mode);
      for (int w = 1; w <= vecs[i].nwin; w++) begin
        sb_window($sformatf("row%0d_win%0d_count", i, w), vecs[i].exp_cnt);
        tick();
        chk($sformatf("row%0d_win%0d_cv_pulse", i, w), int'(count_valid), 0);
        chk($sformatf("row%0d_win%0d_locked", i, w), int'(locked),
            int'(vecs[i].exp_lock && (w >= LOCK_CNT)));
      end
      chk($sformatf("row%0d_err", i), int'(err), int'(vecs[i].exp_err));
    end

    // Loss of lock: err sets, survives relock, clears on clear_err.
    restart(0);
    for (int w = 1; w <= LOCK_CNT; w++) sb_window("lol_lock_count", 8);
    w0 = cv_cyc;
    wait_until(w0 + 1);
    chk("lol_locked", int'(locked), 1);
    wait_until(w0 + 34);
    mode = 3;
    sb_window("lol_last_good", 8);
    sb_window("lol_zero_count", 0);
    tick();
    chk("lol_locked_fall", int'(locked), 0);
    chk("lol_err_set", int'(err), 1);
    mode = 0;
    wait_locked();
    chk("lol_err_sticky", int'(err), 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("lol_err_cleared", int'(err), 0);

    // Bad window ending on the same edge as clear_err: set wins.
    sb_window("coin_sync", 8);
    w0 = cv_cyc;
    wait_until(w0 + 34);
    mode = 3;
    sb_window("coin_good", 8);
    w0 = cv_cyc;
    wait_until(w0 + 35);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("coin_cv", int'(count_valid), 1);
    chk("coin_count", int'(edge_count), 0);
    chk("coin_err", int'(err), 1);
    mode = 0;
    wait_locked();

    // Reset pulse at win=17 while locked.
    sb_window("rst_sync", 8);
    w0 = cv_cyc;
    wait_until(w0 + 17);
    reset = 1'b0;
    tick();
    chk("midrst_edge_count", int'(edge_count), 0);
    chk("midrst_count_valid", int'(count_valid), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_err", int'(err), 0);
    reset = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!count_valid && n < 100);
    chk("midrst_cv_latency", n, WINDOW + 1);
    wait_locked();

    // Enable dropped at win=20 for 3 cycles.
    sb_window("endrop_sync", 8);
    w0 = cv_cyc;
    wait_until(w0 + 20);
    enable = 1'b0;
    tick();
    chk("endrop_locked", int'(locked), 0);
    chk("endrop_cv0", int'(count_valid), 0);
    tick();
    chk("endrop_cv1", int'(count_valid), 0);
    tick();
    chk("endrop_cv2", int'(count_valid), 0);
    enable = 1'b1;
    chk("endrop_hold_count", int'(edge_count), 8);
    n = 0;
    do begin
      tick();
      n++;
    end while (!count_valid && n < 100);
    chk("endrop_cv_latency", n, WINDOW + 1);
    chk("endrop_new_count", int'(edge_count), 8);
    for (int w = 2; w <= LOCK_CNT; w++) begin
      sb_window("endrop_relock_count", 8);
      tick();
      chk($sformatf("endrop_win%0d_locked", w), int'(locked), int'(w >= LOCK_CNT));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Downstream checker for the divide-by-4.5 clock generator; consumes its divided clock output as a data signal in the source `clk` domain.
- Counts rising edges of the divided clock over a fixed window of source cycles and compares the count with an expected value.
- Reports per-window counts, a lock indication after consecutive good windows, and a sticky error on loss of lock.
- Sits between the divider and system status/CSR logic; does not drive any clock.

Parameters:
- WINDOW, 36, source `clk` cycles per measurement window (≥2)
- EXP_EDGES, 8, expected rising edges per window (36/4.5)
- TOL, 1, allowed absolute deviation from EXP_EDGES
- LOCK_CNT, 4, consecutive good windows required to assert `locked` (≥1)
- CNT_W, 8, width of the edge accumulator and `edge_count`

Ports:
- clk  in  1  source clock; all logic on posedge
- reset  in  1  synchronous, active-low reset
- enable  in  1  measurement enable; level-sensitive
- div_clk_in  in  1  divided clock from the divider, asynchronous to the sampling edge
- clear_err  in  1  one-cycle pulse; clears `err`
- edge_count  out  CNT_W  edge count of the last completed window
- count_valid  out  1  one-cycle pulse when `edge_count` updates
- locked  out  1  high while in LOCKED state
- err  out  1  sticky loss-of-lock flag

Behaviour:
- Reset: one clock, synchronous, active-low (`reset`=0 sampled at posedge `clk`); everything is clocked on posedge `clk`.
- Reset values: all outputs, synchronizer flops, counters and FSM return to 0/IDLE.
- Reset asserted mid-window aborts the window; no `count_valid` is produced.
- Input path:
  - 2-flop synchronizer s1 → s2, plus a third flop s3.
  - rise = s2 & ~s3.
  - Edge-to-detect latency is 3 `clk` cycles.
  - An edge is attributed to the window in which `rise` is high.
- Window counter `win` runs 0..WINDOW-1 while not in IDLE and wraps to 0.
- Accumulator `acc` increments on `rise` and saturates at 2^CNT_W-1.
- Window end (`win`==WINDOW-1), on that same posedge:
  - `edge_count` <= `acc` + `rise` (saturating), `count_valid` <= 1, `acc` <= 0.
  - `count_valid` is high for exactly the following cycle and low otherwise.
- Good window: |`edge_count` − EXP_EDGES| ≤ TOL, computed on the value being loaded, unsigned-safe.
- FSM states: IDLE, ACQUIRE, LOCKED.
  - IDLE: `win`, `acc` and good-window count `gcnt` held at 0; `locked`=0.
  - IDLE → ACQUIRE when `enable`=1. The first window starts on the next cycle with `win`=0.
  - ACQUIRE, at window end:
    - Good: `gcnt`++. If `gcnt`+1 == LOCK_CNT, go to LOCKED (`locked`=1 from the next cycle).
    - Bad: `gcnt` <= 0.
  - LOCKED, at window end:
    - Good: stay.
    - Bad: go to ACQUIRE, `gcnt` <= 0, `locked` <= 0, `err` <= 1.
  - Any state, `enable`=0: next state IDLE. The partial window is discarded with no `count_valid`. `edge_count` and `err` are retained.
- `err`:
  - Set only by a LOCKED→ACQUIRE bad window.
  - Cleared by `clear_err`=1.
  - Set and clear on the same cycle: set wins.
- Synchronizer flops run in every state (including IDLE) so edge history is valid on re-enable.

Test Plan:
- Reset, `enable`=1, `div_clk_in` from the 4.5 divider (high 5 of 9 `clk` half-period slots) → every `edge_count`=8. `locked` rises the cycle after the 4th `count_valid`. `err`=0.
- Divide-by-4 stimulus (9 edges/window) → `locked` asserts (within TOL). Divide-by-3 stimulus (12 edges) → `edge_count`=12, `locked` stays 0, `err` stays 0.
- Lock with the 4.5 stimulus, then hold `div_clk_in`=0 → next window `edge_count`=0, `locked` falls, `err`=1 and stays 1 after the input recovers and relocks. A `clear_err` pulse → `err`=0.
- Lock, then force a bad window whose end coincides with a `clear_err` pulse → `err`=1 after that edge.
- `reset`=0 for one cycle at `win`=17 while locked → next cycle all outputs 0, state IDLE. With `enable`=1, the first `count_valid` arrives WINDOW+1 cycles after release.
- Drop `enable` at `win`=20 for 3 cycles, then re-enable → no `count_valid` for the aborted window. `locked`=0 and `gcnt` restarts at 0. `edge_count` holds its last value until the new window completes.
